core_load_store_unit: RTL and testbench

Parametrised load/store unit sitting between the ExperiarCore execute stage and the core SRAM/Wishbone memory port. It accepts one load or store request at a time from the core and generates byte-lane-correct memory beats, splitting misaligned accesses that cross a bus word into two beats. It also sign- or zero-extends load data and reports completion or error back to the core. It generalises the core's fixed 32-bit, aligned-only memory path to configurable bus width and optional misaligned support.

---
 rtl/core_load_store_unit_if.sv | 50 +++++
 rtl/core_load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_core_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_load_store_unit_if.sv
// Core/memory bundle for core_load_store_unit.
// Purpose: carries the core request/response handshake and the memory beat
//          signals between the execute stage, the load/store unit and memory.
// Ports (as interface signals):
//   core_valid/core_ready/core_write/core_funct3/core_address/core_writeData : request
//   core_done/core_error/core_readData                                        : response
//   memoryAddress/memoryByteSelect/memoryWriteEnable/memoryReadEnable/
//   memoryDataWrite                                                           : beat out
//   memoryDataRead/memoryBusy                                                 : beat in
// Modports: slave = the load/store unit, master = the core/memory environment.
interface core_load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  core_valid;
    logic                  core_ready;
    logic                  core_write;
    logic [2:0]            core_funct3;
    logic [ADDR_WIDTH-1:0] core_address;
    logic [31:0]           core_writeData;
    logic                  core_done;
    logic                  core_error;
    logic [31:0]           core_readData;

    logic [ADDR_WIDTH-1:0] memoryAddress;
    logic [BYTES-1:0]      memoryByteSelect;
    logic                  memoryWriteEnable;
    logic                  memoryReadEnable;
    logic [DATA_WIDTH-1:0] memoryDataWrite;
    logic [DATA_WIDTH-1:0] memoryDataRead;
    logic                  memoryBusy;

    modport slave (
        input  core_valid, core_write, core_funct3, core_address, core_writeData,
        input  memoryDataRead, memoryBusy,
        output core_ready, core_done, core_error, core_readData,
        output memoryAddress, memoryByteSelect, memoryWriteEnable, memoryReadEnable,
        output memoryDataWrite
    );

    modport master (
        output core_valid, core_write, core_funct3, core_address, core_writeData,
        output memoryDataRead, memoryBusy,
        input  core_ready, core_done, core_error, core_readData,
        input  memoryAddress, memoryByteSelect, memoryWriteEnable, memoryReadEnable,
        input  memoryDataWrite
    );
endinterface

// File: rtl/core_load_store_unit.sv
// core_load_store_unit
// Purpose: accepts one load/store at a time from the core, issues one or two
//          byte-lane-correct memory beats (two when a misaligned access crosses
//          a bus word), sign/zero-extends load data and signals completion.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : core_load_store_unit_if.slave (core request/response + memory beat)
module core_load_store_unit #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    core_load_store_unit_if.slave       bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WMASK = 2 * BYTES;
    localparam int WDATA = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, FINISH, ERR} state_t;

    state_t state, state_next;

    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [OFF_W-1:0]      req_offset;
    logic [ADDR_WIDTH-1:0] req_base;
    logic [WMASK-1:0]      req_mask;
    logic [WDATA-1:0]      req_data;
    logic                  req_split;
    logic [DATA_WIDTH-1:0] beat0_data;
    logic [31:0]           read_data;

    logic                  accept;
    logic                  beat_done;
    logic [OFF_W-1:0]      in_offset;
    logic [3:0]            in_size_mask;
    logic [WMASK-1:0]      in_mask;
    logic [WDATA-1:0]      in_data;
    logic                  in_funct_ok;
    logic                  in_cross;
    logic                  in_error;

    logic [WDATA-1:0]      load_pair;
    logic [31:0]           load_word;
    logic [31:0]           load_ext;

    // Request decode on the live core inputs, registered on acceptance.
    assign accept    = bus.core_valid && bus.core_ready;
    assign in_offset = bus.core_address[OFF_W-1:0];

    always_comb begin
        case (bus.core_funct3[1:0])
            2'b00:   in_size_mask = 4'b0001;
            2'b01:   in_size_mask = 4'b0011;
            default: in_size_mask = 4'b1111;
        endcase
    end

    // Lanes/data over a double-width window: low half is beat 0, high half beat 1.
    assign in_mask  = WMASK'(in_size_mask) << in_offset;
    assign in_data  = WDATA'(bus.core_writeData) << {in_offset, 3'b000};
    assign in_cross = |in_mask[WMASK-1:BYTES];

    always_comb begin
        if (bus.core_write)
            in_funct_ok = (bus.core_funct3 == 3'b000) || (bus.core_funct3 == 3'b001) ||
                          (bus.core_funct3 == 3'b010);
        else
            in_funct_ok = !((bus.core_funct3 == 3'b011) || (bus.core_funct3 == 3'b110) ||
                            (bus.core_funct3 == 3'b111));
    end

    assign in_error  = !in_funct_ok || (in_cross && (ALLOW_MISALIGNED == 0));
    assign req_split = |req_mask[WMASK-1:BYTES];
    assign beat_done = ((state == BEAT0) || (state == BEAT1)) && !bus.memoryBusy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, FINISH, ERR: begin
                if (accept) state_next = in_error ? ERR : BEAT0;
                else        state_next = IDLE;
            end
            BEAT0:   if (beat_done) state_next = req_split ? BEAT1 : FINISH;
            BEAT1:   if (beat_done) state_next = FINISH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_write  <= 1'b0;
            req_funct3 <= '0;
            req_offset <= '0;
            req_base   <= '0;
            req_mask   <= '0;
            req_data   <= '0;
        end else if (accept) begin
            req_write  <= bus.core_write;
            req_funct3 <= bus.core_funct3;
            req_offset <= in_offset;
            req_base   <= {bus.core_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            req_mask   <= in_mask;
            req_data   <= in_data;
        end
    end

    // Memory outputs depend only on state and registered request fields,
    // so they stay stable while memoryBusy stalls a beat.
    always_comb begin
        bus.core_ready        = 1'b0;
        bus.core_done         = 1'b0;
        bus.core_error        = 1'b0;
        bus.memoryAddress     = '0;
        bus.memoryByteSelect  = '0;
        bus.memoryWriteEnable = 1'b0;
        bus.memoryReadEnable  = 1'b0;
        bus.memoryDataWrite   = '0;
        case (state)
            IDLE: bus.core_ready = 1'b1;
            FINISH: begin
                bus.core_ready = 1'b1;
                bus.core_done  = 1'b1;
            end
            ERR: begin
                bus.core_ready = 1'b1;
                bus.core_done  = 1'b1;
                bus.core_error = 1'b1;
            end
            BEAT0: begin
                bus.memoryAddress     = req_base;
                bus.memoryByteSelect  = req_mask[BYTES-1:0];
                bus.memoryWriteEnable = req_write;
                bus.memoryReadEnable  = !req_write;
                bus.memoryDataWrite   = req_write ? req_data[DATA_WIDTH-1:0] : '0;
            end
            BEAT1: begin
                bus.memoryAddress     = req_base + ADDR_WIDTH'(BYTES);
                bus.memoryByteSelect  = req_mask[WMASK-1:BYTES];
                bus.memoryWriteEnable = req_write;
                bus.memoryReadEnable  = !req_write;
                bus.memoryDataWrite   = req_write ? req_data[WDATA-1:DATA_WIDTH] : '0;
            end
            default: ;
        endcase
    end

    // Final beat data comes straight off the bus so the result can be
    // registered on the completing edge; beat 0 of a split load is held.
    assign load_pair = (state == BEAT1) ? {bus.memoryDataRead, beat0_data}
                                        : {{DATA_WIDTH{1'b0}}, bus.memoryDataRead};
    assign load_word = 32'(load_pair >> {req_offset, 3'b000});

    always_comb begin
        case (req_funct3)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_ext = {24'h000000, load_word[7:0]};
            3'b101:  load_ext = {16'h0000, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat0_data <= '0;
            read_data  <= '0;
        end else begin
            if ((state == BEAT0) && beat_done)
                beat0_data <= bus.memoryDataRead;
            if (!req_write && beat_done && ((state == BEAT1) || !req_split))
                read_data <= load_ext;
        end
    end

    assign bus.core_readData = read_data;
endmodule

// File: tb/tb_core_load_store_unit.sv
// Testbench for core_load_store_unit: three instances (32-bit misaligned,
// 32-bit strict, 64-bit misaligned) driven one request at a time and checked
// cycle by cycle against a byte-level reference model of the memory access.
module tb_core_load_store_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        busy;
    logic        force_en;
    logic [63:0] force_data;
    logic [7:0]  salt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_rd [3];

    typedef struct packed {
        logic        ready;
        logic        done;
        logic        error;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [7:0]  sel;
        logic        we;
        logic        re;
        logic [63:0] wdata;
    } obs_t;

    core_load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    core_load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_s ();
    core_load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus_w ();

    core_load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ALLOW_MISALIGNED(1))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    core_load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ALLOW_MISALIGNED(0))
        u_dut_strict (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    core_load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ALLOW_MISALIGNED(1))
        u_dut_wide (.clk(clk), .rst_n(rst_n), .bus(bus_w));

    // Memory content: a fixed function of the byte address (salted), or a
    // forced word repeated at every beat address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a, input logic [7:0] s);
        logic [7:0] m;
        m = a[7:0] * 8'd37;
        return m ^ a[15:8] ^ a[31:24] ^ s;
    endfunction

    function automatic logic [63:0] mem_word(input logic [31:0] a, input int nbytes,
                                             input logic fe, input logic [63:0] fd,
                                             input logic [7:0] s);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < nbytes; k++)
            w[k*8 +: 8] = fe ? fd[k*8 +: 8] : mem_byte(a + 32'(k), s);
        return w;
    endfunction

    assign bus_a.memoryDataRead = 32'(mem_word(bus_a.memoryAddress, 4, force_en, force_data, salt));
    assign bus_s.memoryDataRead = 32'(mem_word(bus_s.memoryAddress, 4, force_en, force_data, salt));
    assign bus_w.memoryDataRead = mem_word(bus_w.memoryAddress, 8, force_en, force_data, salt);

    assign bus_a.core_valid = valid[0];
    assign bus_s.core_valid = valid[1];
    assign bus_w.core_valid = valid[2];
    assign bus_a.core_write = req_write;
    assign bus_s.core_write = req_write;
    assign bus_w.core_write = req_write;
    assign bus_a.core_funct3 = req_funct3;
    assign bus_s.core_funct3 = req_funct3;
    assign bus_w.core_funct3 = req_funct3;
    assign bus_a.core_address = req_address;
    assign bus_s.core_address = req_address;
    assign bus_w.core_address = req_address;
    assign bus_a.core_writeData = req_wdata;
    assign bus_s.core_writeData = req_wdata;
    assign bus_w.core_writeData = req_wdata;
    assign bus_a.memoryBusy = busy;
    assign bus_s.memoryBusy = busy;
    assign bus_w.memoryBusy = busy;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t sample(input int inst);
        obs_t o;
        o = '0;
        case (inst)
            0: begin
                o.ready = bus_a.core_ready; o.done = bus_a.core_done; o.error = bus_a.core_error;
                o.rdata = bus_a.core_readData; o.addr = bus_a.memoryAddress;
                o.sel = 8'(bus_a.memoryByteSelect); o.we = bus_a.memoryWriteEnable;
                o.re = bus_a.memoryReadEnable; o.wdata = 64'(bus_a.memoryDataWrite);
            end
            1: begin
                o.ready = bus_s.core_ready; o.done = bus_s.core_done; o.error = bus_s.core_error;
                o.rdata = bus_s.core_readData; o.addr = bus_s.memoryAddress;
                o.sel = 8'(bus_s.memoryByteSelect); o.we = bus_s.memoryWriteEnable;
                o.re = bus_s.memoryReadEnable; o.wdata = 64'(bus_s.memoryDataWrite);
            end
            default: begin
                o.ready = bus_w.core_ready; o.done = bus_w.core_done; o.error = bus_w.core_error;
                o.rdata = bus_w.core_readData; o.addr = bus_w.memoryAddress;
                o.sel = bus_w.memoryByteSelect; o.we = bus_w.memoryWriteEnable;
                o.re = bus_w.memoryReadEnable; o.wdata = bus_w.memoryDataWrite;
            end
        endcase
        return o;
    endfunction

    // Byte the memory holds at address a, as seen through an nb-byte bus.
    function automatic logic [7:0] exp_byte(input logic [31:0] a, input int nb);
        int lane;
        lane = int'(a % 32'(nb));
        return force_en ? force_data[lane*8 +: 8] : mem_byte(a, salt);
    endfunction

    // Issue one request from a negedge where the instance is ready, then follow
    // it cycle by cycle. Returns at the negedge of the done cycle.
    // busy_n >= 0: that many stall cycles at the start of each beat; <0: random.
    task automatic run_req(input int inst, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int busy_n);
        int nb, nsz, off, phase, busy_cnt, g;
        logic ok, split, err, done_seen, bz;
        logic [31:0] ld, base0;
        logic [7:0]  e_sel;
        logic [63:0] e_wd;
        obs_t o;

        nb    = (inst == 2) ? 8 : 4;
        nsz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ok    = w ? (f3 <= 3'd2) : !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
        off   = int'(a % 32'(nb));
        split = (off + nsz) > nb;
        err   = !ok || (split && (inst == 1));
        base0 = a - 32'(off);

        ld = '0;
        for (int i = 0; i < nsz; i++) ld[i*8 +: 8] = exp_byte(a + 32'(i), nb);
        if (nsz == 1)      ld = f3[2] ? {24'h0, ld[7:0]}  : {{24{ld[7]}}, ld[7:0]};
        else if (nsz == 2) ld = f3[2] ? {16'h0, ld[15:0]} : {{16{ld[15]}}, ld[15:0]};

        req_write = w; req_funct3 = f3; req_address = a; req_wdata = wd;
        valid[inst] = 1'b1;
        busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid[inst] = 1'b0;

        phase = err ? 3 : 0;   // 0 beat0, 1 beat1, 2 finish, 3 error
        busy_cnt = 0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
            o = sample(inst);
            if (phase >= 2) begin
                check("done", o.done, 1'b1);
                check("error", o.error, phase == 3);
                check("ready_at_done", o.ready, 1'b1);
                check("bus_idle", {o.addr, o.sel, o.we, o.re, o.wdata}, '0);
                if (phase == 2 && !w) exp_rd[inst] = ld;
                check("read_data", o.rdata, exp_rd[inst]);
                done_seen = 1'b1;
            end else begin
                e_sel = '0;
                e_wd  = '0;
                for (int k = 0; k < nb; k++) begin
                    g = phase * nb + k;
                    if (g >= off && g < off + nsz) e_sel[k] = 1'b1;
                    if (w && g >= off && g < off + 4) e_wd[k*8 +: 8] = wd[(g - off)*8 +: 8];
                end
                check("flags_in_beat", {o.ready, o.done, o.error}, 3'b000);
                check(phase == 0 ? "beat0" : "beat1", {o.addr, o.sel, o.we, o.re, o.wdata},
                      {base0 + 32'(phase * nb), e_sel, w, !w, e_wd});
                bz = (busy_n >= 0) ? (busy_cnt < busy_n) : ($urandom_range(0, 3) == 0);
                busy = bz;
                if (bz) busy_cnt++;
                else begin
                    busy_cnt = 0;
                    phase = (phase == 0 && split) ? 1 : 2;
                end
                // Stray request while busy; the unit must ignore it.
                if ($urandom_range(0, 2) == 0) begin
                    valid[inst] = 1'b1;
                    req_write   = 1'($urandom);
                    req_funct3  = 3'($urandom);
                    req_address = $urandom;
                end else begin
                    valid[inst] = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        busy = 1'b0;
        valid[inst] = 1'b0;
        check("completed", done_seen, 1'b1);
    endtask

    obs_t ob;
    int   inst_r;
    logic [31:0] addr_r;

    initial begin
        valid = '0; req_write = 1'b0; req_funct3 = '0; req_address = '0; req_wdata = '0;
        busy = 1'b0; force_en = 1'b0; force_data = '0; salt = '0;
        for (int i = 0; i < 3; i++) exp_rd[i] = '0;

        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            ob = sample(i);
            check("reset_flags", {ob.ready, ob.done, ob.error}, 3'b100);
            check("reset_rdata", ob.rdata, 32'h0);
            check("reset_bus", {ob.addr, ob.sel, ob.we, ob.re, ob.wdata}, '0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        force_en = 1'b1;
        force_data = 64'h0000_0000_DEAD_BEEF;
        run_req(0, 1'b0, 3'b010, 32'h100, 32'h0, 0);
        check("lw_deadbeef", bus_a.core_readData, 32'hDEADBEEF);
        run_req(1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
        force_data = 64'h0000_0000_8012_3456;
        run_req(0, 1'b0, 3'b000, 32'h103, 32'h0, 0);
        check("lb_sign", bus_a.core_readData, 32'hFFFFFF80);
        run_req(0, 1'b0, 3'b100, 32'h103, 32'h0, 0);
        check("lbu_zero", bus_a.core_readData, 32'h00000080);
        force_en = 1'b0;
        run_req(0, 1'b1, 3'b010, 32'h102, 32'h11223344, 0);
        run_req(1, 1'b0, 3'b001, 32'h103, 32'h0, 0);
        check("strict_keep_rdata", bus_s.core_readData, 32'hDEADBEEF);
        run_req(0, 1'b1, 3'b011, 32'h100, 32'hA5A5A5A5, 0);
        run_req(0, 1'b0, 3'b010, 32'h200, 32'h0, 3);

        // Reset in the middle of beat 1 of a split load
        req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h302;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        busy = 1'b0;
        @(posedge clk);
        #2;
        ob = sample(0);
        check("beat1_live", {ob.re, ob.sel}, {1'b1, 8'b0000_0011});
        rst_n = 1'b0;
        #1;
        ob = sample(0);
        check("async_reset_flags", {ob.ready, ob.done, ob.error}, 3'b100);
        check("async_reset_bus", {ob.addr, ob.sel, ob.we, ob.re, ob.wdata}, '0);
        check("async_reset_rdata", ob.rdata, 32'h0);
        for (int i = 0; i < 3; i++) exp_rd[i] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ob = sample(0);
            check("no_done_after_reset", ob.done, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_req(0, 1'b0, 3'b010, 32'h400, 32'h0, 0);

        // Wide bus and address wrap
        run_req(2, 1'b0, 3'b010, 32'h104, 32'h0, 0);
        run_req(2, 1'b0, 3'b010, 32'h106, 32'h0, 0);
        run_req(2, 1'b1, 3'b001, 32'h10F, 32'hCAFEF00D, -1);
        run_req(0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, -1);
        run_req(2, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0, -1);

        // Randomized requests
        for (int n = 0; n < 300; n++) begin
            inst_r = $urandom_range(0, 2);
            salt   = 8'($urandom);
            addr_r = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                                 : $urandom;
            run_req(inst_r, 1'($urandom), 3'($urandom), addr_r, $urandom, -1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
